// File: rtl/pipe_ctrl_defs.sv
// Shared encodings for the pipeline sequencing controller: PC source select,
// memory-wait FSM states and the default performance counter width.
package pipe_ctrl_defs;

    localparam int CNT_W_DEF = 32;

    localparam logic [1:0] PCSRC_SEQ  = 2'd0;
    localparam logic [1:0] PCSRC_ID   = 2'd1;
    localparam logic [1:0] PCSRC_PEND = 2'd2;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear takes precedence over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign q = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Fixed-priority stall/flush/hold resolution for the 5-stage pipeline, with a
// buffered redirect for fetch misses, a data-memory wait watchdog and counters.
module hazard_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             Branch_id,
    input  logic             Jump_id,
    input  logic [31:0]      JumpAddr_id,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             MEMWBFlush,
    output logic [1:0]       PCSrc,
    output logic [31:0]      redir_pc,
    output logic             Stall,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic        load_use, mem_hold, redirect;
    logic        pend_reg, pend_next;
    logic [31:0] redir_reg, redir_next;
    logic        flush_inc;
    logic        err_reg;
    mem_state_e  state_reg, state_next;
    logic [WAIT_W-1:0] wait_q;
    logic        wait_inc, wait_clr;

    assign load_use = MemRead_ex && (rdAddr_ex != 5'd0) &&
                      ((rs1Used_id && (rdAddr_ex == rs1Addr_id)) ||
                       (rs2Used_id && (rdAddr_ex == rs2Addr_id)));
    assign mem_hold = dmem_req && !dmem_ready;
    assign redirect = Branch_id || Jump_id;

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        EXMEMWrite = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        MEMWBFlush = 1'b0;
        PCSrc      = PCSRC_SEQ;
        Stall      = 1'b0;
        pend_next  = pend_reg;
        redir_next = redir_reg;
        flush_inc  = 1'b0;
        if (mem_hold) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBFlush = 1'b1;
        end else if (load_use) begin
            // Redirect is dropped here; the branch stays in ID and re-resolves.
            Stall     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else if (pend_reg) begin
            IFIDFlush = 1'b1;
            if (imem_ready) begin
                PCSrc     = PCSRC_PEND;
                pend_next = 1'b0;
            end else begin
                PCWrite = 1'b0;
            end
        end else if (redirect) begin
            IFIDFlush = 1'b1;
            flush_inc = 1'b1;
            if (imem_ready) begin
                PCSrc = PCSRC_ID;
            end else begin
                PCWrite    = 1'b0;
                redir_next = JumpAddr_id;
                pend_next  = 1'b1;
            end
        end else if (!imem_ready) begin
            PCWrite   = 1'b0;
            IFIDFlush = 1'b1;
        end
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            MEMWBFlush = 1'b1;
            PCSrc      = PCSRC_SEQ;
            Stall      = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            M_IDLE:  if (mem_hold) state_next = M_WAIT;
            M_WAIT:  if (dmem_ready) state_next = M_IDLE;
            default: state_next = M_IDLE;
        endcase
    end

    assign wait_clr = (state_reg == M_IDLE) && mem_hold;
    assign wait_inc = (state_reg == M_WAIT) && (wait_q != WAIT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg  <= 1'b0;
            redir_reg <= '0;
            state_reg <= M_IDLE;
            err_reg   <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            redir_reg <= redir_next;
            state_reg <= state_next;
            // Flag lands on the same edge the wait count reaches MEM_TIMEOUT.
            if ((state_reg == M_WAIT) && (wait_q >= WAIT_LAST)) begin
                err_reg <= 1'b1;
            end
        end
    end

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .q     (wait_q)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!PCWrite),
        .clr   (1'b0),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (1'b0),
        .q     (flush_cnt)
    );

    assign redir_pc        = redir_reg;
    assign mem_timeout_err = err_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; control outputs are compared as one packed
// vector {PCW,IFIDW,IDEXW,EXMEMW,IFIDF,IDEXF,MEMWBF,PCSrc[1:0],Stall}.
module tb_hazard_ctrl;

    localparam logic [9:0] C_IDLE  = 10'b1111_000_00_0;
    localparam logic [9:0] C_RST   = 10'b0000_111_00_0;
    localparam logic [9:0] C_LU    = 10'b0011_010_00_1;
    localparam logic [9:0] C_HIT   = 10'b1111_100_01_0;
    localparam logic [9:0] C_MISS  = 10'b0111_100_00_0;
    localparam logic [9:0] C_DRAIN = 10'b1111_100_10_0;
    localparam logic [9:0] C_HOLD  = 10'b0000_001_00_0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_ex;
    logic [4:0]  rdAddr_ex, rs1Addr_id, rs2Addr_id;
    logic        rs1Used_id, rs2Used_id, Branch_id, Jump_id;
    logic [31:0] JumpAddr_id;
    logic        imem_ready, dmem_req, dmem_ready;
    logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
    logic        IFIDFlush, IDEXFlush, MEMWBFlush, Stall, mem_timeout_err;
    logic [1:0]  PCSrc;
    logic [31:0] redir_pc, stall_cnt, flush_cnt;
    logic [9:0]  ctl;

    int checks = 0;
    int failures = 0;

    assign ctl = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                  IFIDFlush, IDEXFlush, MEMWBFlush, PCSrc, Stall};

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
        .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
        .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
        .Branch_id(Branch_id), .Jump_id(Jump_id), .JumpAddr_id(JumpAddr_id),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
        .EXMEMWrite(EXMEMWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .MEMWBFlush(MEMWBFlush), .PCSrc(PCSrc), .redir_pc(redir_pc), .Stall(Stall),
        .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read 4 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
        rs1Used_id = 0; rs2Used_id = 0; Branch_id = 0; Jump_id = 0;
        JumpAddr_id = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #4;
        checks++; if (ctl !== C_RST) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
        checks++; if ({stall_cnt, flush_cnt, redir_pc} !== 96'd0) begin failures++; $display("FAIL reset_regs got=%h/%h/%h exp=0", stall_cnt, flush_cnt, redir_pc); end
        checks++; if (mem_timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", mem_timeout_err); end
        tick();
        rst_n = 1;
        #4;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL idle_ctl got=%b exp=%b", ctl, C_IDLE); end
        tick();
    endtask

    task automatic test_load_use();
        MemRead_ex = 1; rdAddr_ex = 5; rs1Addr_id = 5; rs1Used_id = 1;
        #4;
        checks++; if (ctl !== C_LU) begin failures++; $display("FAIL load_use_rs1 got=%b exp=%b", ctl, C_LU); end
        tick();
        rdAddr_ex = 0; rs1Addr_id = 0;
        #4;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL load_use_x0 got=%b exp=%b", ctl, C_IDLE); end
        rdAddr_ex = 7; rs1Addr_id = 1; rs2Addr_id = 7; rs2Used_id = 0;
        #1;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL load_use_rs2_unused got=%b exp=%b", ctl, C_IDLE); end
        rs2Used_id = 1;
        #1;
        checks++; if (ctl !== C_LU) begin failures++; $display("FAIL load_use_rs2 got=%b exp=%b", ctl, C_LU); end
        tick();
        idle_inputs();
        #4;
        checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL load_use_stall_cnt got=%0d exp=2", stall_cnt); end
        tick();
    endtask

    task automatic test_redirect_hit();
        Branch_id = 1; JumpAddr_id = 32'h100;
        #4;
        checks++; if (ctl !== C_HIT) begin failures++; $display("FAIL hit_ctl got=%b exp=%b", ctl, C_HIT); end
        tick();
        MemRead_ex = 1; rdAddr_ex = 3; rs2Addr_id = 3; rs2Used_id = 1;
        #4;
        checks++; if (ctl !== C_LU) begin failures++; $display("FAIL hit_vs_load_use got=%b exp=%b", ctl, C_LU); end
        tick();
        idle_inputs();
        #4;
        checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL hit_flush_cnt got=%0d exp=1", flush_cnt); end
        checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL hit_stall_cnt got=%0d exp=3", stall_cnt); end
        tick();
    endtask

    task automatic test_redirect_miss();
        Jump_id = 1; imem_ready = 0; JumpAddr_id = 32'h200;
        #4;
        checks++; if (ctl !== C_MISS) begin failures++; $display("FAIL miss_first got=%b exp=%b", ctl, C_MISS); end
        tick();
        Jump_id = 0; JumpAddr_id = 32'h999;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++; if (ctl !== C_MISS) begin failures++; $display("FAIL miss_drain%0d got=%b exp=%b", i, ctl, C_MISS); end
            checks++; if (redir_pc !== 32'h200) begin failures++; $display("FAIL miss_redir_pc%0d got=%h exp=00000200", i, redir_pc); end
            tick();
        end
        imem_ready = 1;
        #4;
        checks++; if (ctl !== C_DRAIN) begin failures++; $display("FAIL miss_final got=%b exp=%b", ctl, C_DRAIN); end
        tick();
        #4;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL miss_pend_clear got=%b exp=%b", ctl, C_IDLE); end
        checks++; if ({stall_cnt, flush_cnt} !== {32'd7, 32'd2}) begin failures++; $display("FAIL miss_cnts got=%0d/%0d exp=7/2", stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_hold_during_drain();
        Jump_id = 1; imem_ready = 0; JumpAddr_id = 32'h300;
        tick();
        Jump_id = 0; imem_ready = 1; dmem_req = 1; dmem_ready = 0;
        #4;
        checks++; if (ctl !== C_HOLD) begin failures++; $display("FAIL drain_hold got=%b exp=%b", ctl, C_HOLD); end
        tick();
        dmem_ready = 1;
        #4;
        checks++; if (ctl !== C_DRAIN || redir_pc !== 32'h300) begin failures++; $display("FAIL drain_release got=%b/%h exp=%b/00000300", ctl, redir_pc, C_DRAIN); end
        tick();
        idle_inputs();
        #4;
        checks++; if ({stall_cnt, flush_cnt} !== {32'd9, 32'd3}) begin failures++; $display("FAIL drain_cnts got=%0d/%0d exp=9/3", stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_mem_wait();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            MemRead_ex = (i == 1); rdAddr_ex = 5; rs1Addr_id = 5; rs1Used_id = 1;
            #4;
            checks++; if (ctl !== C_HOLD) begin failures++; $display("FAIL mem_wait%0d got=%b exp=%b", i, ctl, C_HOLD); end
            tick();
        end
        MemRead_ex = 0; dmem_ready = 1;
        #4;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL mem_release got=%b exp=%b", ctl, C_IDLE); end
        tick();
        idle_inputs();
        #4;
        checks++; if (stall_cnt !== 32'd13) begin failures++; $display("FAIL mem_stall_cnt got=%0d exp=13", stall_cnt); end
        tick();
    endtask

    task automatic test_timeout();
        pulse_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            #4;
            checks++; if (mem_timeout_err !== (i == 5)) begin failures++; $display("FAIL timeout_cyc%0d got=%b exp=%b", i, mem_timeout_err, (i == 5)); end
            tick();
        end
        dmem_ready = 1;
        tick();
        idle_inputs();
        #4;
        checks++; if (mem_timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout_err); end
        checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL timeout_stall_cnt got=%0d exp=5", stall_cnt); end
        tick();
        pulse_reset();
        #4;
        checks++; if (mem_timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", mem_timeout_err); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        Jump_id = 1; imem_ready = 0; JumpAddr_id = 32'h400;
        tick();
        Jump_id = 0;
        #2;
        rst_n = 0;
        #2;
        checks++; if (ctl !== C_RST) begin failures++; $display("FAIL mid_drain_rst got=%b exp=%b", ctl, C_RST); end
        tick();
        rst_n = 1; imem_ready = 1;
        #4;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL mid_drain_after got=%b exp=%b", ctl, C_IDLE); end
        checks++; if ({stall_cnt, flush_cnt, redir_pc} !== 96'd0) begin failures++; $display("FAIL mid_drain_regs got=%h/%h/%h exp=0", stall_cnt, flush_cnt, redir_pc); end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_load_use();
        test_redirect_hit();
        test_redirect_miss();
        test_hold_during_drain();
        test_mem_wait();
        test_timeout();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
